// File: rtl/adxl355_reg_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : adxl355_reg_bank_if
//  Description : Byte-level handshake between spi_slave (master side) and the
//                ADXL355-style register bank (slave side), all in mems_clk.
//  Signals     : cs_n                 chip select, synchronised to mems_clk
//                spi_addr_valid       1-cycle start-of-transaction strobe
//                spi_slave_wr_rd_addr 7-bit start address
//                wr_rd                1 = read, 0 = write (with spi_addr_valid)
//                spi_data_valid       1-cycle byte strobe (write byte / read
//                                     byte shifted out)
//                spi_slave_wr_data    write byte
//                reg_slave_rd_data    read byte returned to spi_slave
//                reg_slave_rd_valid   level, read byte valid
//  Revision    : 1.0  initial release
// ============================================================================
interface adxl355_reg_bank_if;
    logic       cs_n;
    logic       spi_addr_valid;
    logic [6:0] spi_slave_wr_rd_addr;
    logic       wr_rd;
    logic       spi_data_valid;
    logic [7:0] spi_slave_wr_data;
    logic [7:0] reg_slave_rd_data;
    logic       reg_slave_rd_valid;

    modport master (
        output cs_n, spi_addr_valid, spi_slave_wr_rd_addr, wr_rd,
               spi_data_valid, spi_slave_wr_data,
        input  reg_slave_rd_data, reg_slave_rd_valid
    );

    modport slave (
        input  cs_n, spi_addr_valid, spi_slave_wr_rd_addr, wr_rd,
               spi_data_valid, spi_slave_wr_data,
        output reg_slave_rd_data, reg_slave_rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/adxl355_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : adxl355_reg_bank
//  Description : Register-file responder behind spi_slave. Decodes address /
//                data strobes, holds ID, status, sample and config registers,
//                returns read bytes with a fixed latency and supports burst
//                access with 7-bit wrapping auto-increment. Sensor samples
//                are snapshotted so one read burst never mixes two samples.
//  Ports       : mems_clk     sole clock
//                rst_n        asynchronous active-low reset
//                bus          adxl355_reg_bank_if.slave handshake to spi_slave
//                sample_vld   1-cycle pulse, new x/y/z/temp sample
//                x/y/z_data   signed 20-bit acceleration samples
//                temp_data    12-bit temperature sample
//                range_cfg    RANGE[1:0] to sensor core
//                standby      POWER_CTL[0]
//  Revision    : 1.0  initial release
// ============================================================================
module adxl355_reg_bank #(
    parameter int         RD_LATENCY = 2,
    parameter logic [7:0] DEVID_AD   = 8'hAD,
    parameter logic [7:0] DEVID_MST  = 8'h1D,
    parameter logic [7:0] PARTID     = 8'hED,
    parameter logic [7:0] REVID      = 8'h01
) (
    input  wire logic               mems_clk,
    input  wire logic               rst_n,
    adxl355_reg_bank_if.slave       bus,
    input  wire logic               sample_vld,
    input  wire logic signed [19:0] x_data,
    input  wire logic signed [19:0] y_data,
    input  wire logic signed [19:0] z_data,
    input  wire logic        [11:0] temp_data,
    output logic             [1:0]  range_cfg,
    output logic                    standby
);

    localparam logic [3:0] c_LAT_LAST   = 4'(RD_LATENCY - 1);
    localparam logic [7:0] c_FILTER_RST = 8'h00;
    localparam logic [7:0] c_RANGE_RST  = 8'h81;
    localparam logic [7:0] c_POWER_RST  = 8'h01;
    localparam logic [7:0] c_RESET_KEY  = 8'h52;
    localparam logic [6:0] c_A_STATUS   = 7'h04;
    localparam logic [6:0] c_A_FILTER   = 7'h28;
    localparam logic [6:0] c_A_RANGE    = 7'h2C;
    localparam logic [6:0] c_A_POWER    = 7'h2D;
    localparam logic [6:0] c_A_RESET    = 7'h2F;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RD_WAIT    = 2'd1,
        ST_RD_PRESENT = 2'd2,
        ST_WR         = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [6:0]  r_addr;
    logic [3:0]  r_cnt;
    logic        r_rd_valid;
    logic [7:0]  r_rd_data;
    logic        r_cs_q;

    logic [7:0]  r_filter;
    logic [7:0]  r_range;
    logic [7:0]  r_power;

    logic [19:0] r_x, r_y, r_z;
    logic [11:0] r_temp;
    logic [19:0] r_pend_x, r_pend_y, r_pend_z;
    logic [11:0] r_pend_temp;
    logic        r_pend_vld;
    logic        r_data_rdy;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [6:0]  w_addr_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_rd_valid_nxt;
    logic [7:0]  w_rd_data_nxt;
    logic        w_wr_en;
    logic        w_rd_consume;
    logic        w_cs_rise;
    logic        w_in_read;
    logic        w_status_clr;
    logic [7:0]  w_rd_mux;

    assign w_cs_rise    = bus.cs_n & ~r_cs_q;
    assign w_in_read    = (r_state == ST_RD_WAIT) || (r_state == ST_RD_PRESENT);
    assign w_status_clr = w_rd_consume && (r_addr == c_A_STATUS);

    assign bus.reg_slave_rd_data  = r_rd_data;
    assign bus.reg_slave_rd_valid = r_rd_valid;
    assign range_cfg              = r_range[1:0];
    assign standby                = r_power[0];

    // ------------------------------------------------------------------
    // Read decode. Shadow registers only change outside a read
    // transaction, so every byte of one burst sees the same sample.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = 8'h00;
        case (r_addr)
            7'h00:      w_rd_mux = DEVID_AD;
            7'h01:      w_rd_mux = DEVID_MST;
            7'h02:      w_rd_mux = PARTID;
            7'h03:      w_rd_mux = REVID;
            c_A_STATUS: w_rd_mux = {7'b0, r_data_rdy};
            7'h06:      w_rd_mux = {4'b0, r_temp[11:8]};
            7'h07:      w_rd_mux = r_temp[7:0];
            7'h08:      w_rd_mux = r_x[19:12];
            7'h09:      w_rd_mux = r_x[11:4];
            7'h0A:      w_rd_mux = {r_x[3:0], 4'b0};
            7'h0B:      w_rd_mux = r_y[19:12];
            7'h0C:      w_rd_mux = r_y[11:4];
            7'h0D:      w_rd_mux = {r_y[3:0], 4'b0};
            7'h0E:      w_rd_mux = r_z[19:12];
            7'h0F:      w_rd_mux = r_z[11:4];
            7'h10:      w_rd_mux = {r_z[3:0], 4'b0};
            c_A_FILTER: w_rd_mux = r_filter;
            c_A_RANGE:  w_rd_mux = r_range;
            c_A_POWER:  w_rd_mux = r_power;
            default:    w_rd_mux = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction FSM: next state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_cnt_nxt      = r_cnt;
        w_rd_valid_nxt = r_rd_valid;
        w_rd_data_nxt  = r_rd_data;
        w_wr_en        = 1'b0;
        w_rd_consume   = 1'b0;

        if (w_cs_rise) begin
            // End of frame always wins; rd_data is left holding.
            w_state_nxt    = ST_IDLE;
            w_rd_valid_nxt = 1'b0;
        end else if (bus.spi_addr_valid) begin
            // New header from any state restarts the transaction.
            w_addr_nxt     = bus.spi_slave_wr_rd_addr;
            w_cnt_nxt      = 4'd0;
            w_rd_valid_nxt = 1'b0;
            w_state_nxt    = bus.wr_rd ? ST_RD_WAIT : ST_WR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                end
                ST_RD_WAIT: begin
                    if (r_cnt == c_LAT_LAST) begin
                        w_state_nxt    = ST_RD_PRESENT;
                        w_rd_valid_nxt = 1'b1;
                        w_rd_data_nxt  = w_rd_mux;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                ST_RD_PRESENT: begin
                    if (bus.spi_data_valid) begin
                        w_rd_consume   = 1'b1;
                        w_rd_valid_nxt = 1'b0;
                        w_addr_nxt     = r_addr + 7'd1;
                        w_cnt_nxt      = 4'd0;
                        w_state_nxt    = ST_RD_WAIT;
                    end
                end
                ST_WR: begin
                    if (bus.spi_data_valid) begin
                        w_wr_en    = 1'b1;
                        w_addr_nxt = r_addr + 7'd1;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_rd_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge mems_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= 7'd0;
            r_cnt      <= 4'd0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
            r_cs_q     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_cs_q     <= bus.cs_n;
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers. The reset key restores all three at the
    // write edge, so the defaults are visible the following cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge mems_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filter <= c_FILTER_RST;
            r_range  <= c_RANGE_RST;
            r_power  <= c_POWER_RST;
        end else if (w_wr_en) begin
            case (r_addr)
                c_A_FILTER: r_filter <= bus.spi_slave_wr_data;
                c_A_RANGE:  r_range  <= bus.spi_slave_wr_data;
                c_A_POWER:  r_power  <= bus.spi_slave_wr_data;
                c_A_RESET: begin
                    if (bus.spi_slave_wr_data == c_RESET_KEY) begin
                        r_filter <= c_FILTER_RST;
                        r_range  <= c_RANGE_RST;
                        r_power  <= c_POWER_RST;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sample snapshot. Outside a read, samples go straight to the shadow
    // set. During a read they park in the pending buffer (newest wins)
    // and are published at the end of the frame. A sample loaded directly
    // also discards anything pending so an older sample cannot later
    // overwrite a newer one.
    // ------------------------------------------------------------------
    always_ff @(posedge mems_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= 20'd0;
            r_y         <= 20'd0;
            r_z         <= 20'd0;
            r_temp      <= 12'd0;
            r_pend_x    <= 20'd0;
            r_pend_y    <= 20'd0;
            r_pend_z    <= 20'd0;
            r_pend_temp <= 12'd0;
            r_pend_vld  <= 1'b0;
            r_data_rdy  <= 1'b0;
        end else begin
            if (sample_vld && (w_cs_rise || !w_in_read)) begin
                r_x        <= x_data;
                r_y        <= y_data;
                r_z        <= z_data;
                r_temp     <= temp_data;
                r_pend_vld <= 1'b0;
                r_data_rdy <= 1'b1;
            end else if (w_cs_rise && r_pend_vld) begin
                r_x        <= r_pend_x;
                r_y        <= r_pend_y;
                r_z        <= r_pend_z;
                r_temp     <= r_pend_temp;
                r_pend_vld <= 1'b0;
                r_data_rdy <= 1'b1;
            end else begin
                if (sample_vld) begin
                    r_pend_x    <= x_data;
                    r_pend_y    <= y_data;
                    r_pend_z    <= z_data;
                    r_pend_temp <= temp_data;
                    r_pend_vld  <= 1'b1;
                end
                if (w_status_clr) begin
                    r_data_rdy <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
